// File: rtl/plane_recip_div.sv
// Sequential radix-2 restoring divider: recip = min(2^NUM_LOG2 / denom, 2^RECIP_W-1).
// One quotient bit per clock, so every request commits RECIP_W clocks after start.
module plane_recip_div #(
   parameter int DENOM_W  = 9,
   parameter int RECIP_W  = 11,
   parameter int NUM_LOG2 = 16
) (
   input  logic               clk48,
   input  logic               rst_n,
   input  logic               start,
   input  logic [DENOM_W-1:0] denom,
   output logic [RECIP_W-1:0] recip,
   output logic               busy,
   output logic               done
);

   localparam int REM_W = NUM_LOG2 + 1;
   // Wide enough that d<<k never truncates and the remainder fits with headroom.
   localparam int CMP_W = (DENOM_W + RECIP_W > NUM_LOG2 + 2) ? DENOM_W + RECIP_W : NUM_LOG2 + 2;
   localparam int K_W   = (RECIP_W > 1) ? $clog2(RECIP_W) : 1;

   localparam logic [REM_W-1:0]   REM_INIT  = {1'b1, {NUM_LOG2{1'b0}}};
   localparam logic [RECIP_W-1:0] RECIP_MAX = '1;
   localparam logic [K_W-1:0]     K_INIT    = K_W'(RECIP_W - 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t               state_q, state_d;
   logic [REM_W-1:0]     rem_q, rem_d;
   logic [DENOM_W-1:0]   d_q, d_d;
   logic [K_W-1:0]       k_q, k_d;
   logic [RECIP_W-1:0]   q_q, q_d;
   logic                 sat_q, sat_d;
   logic [RECIP_W-1:0]   recip_q, recip_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic [CMP_W-1:0]     trial;
   logic [CMP_W-1:0]     rem_ext;
   logic [CMP_W-1:0]     diff;
   logic                 sat_new;

   assign trial   = CMP_W'(d_q) << k_q;
   assign rem_ext = CMP_W'(rem_q);
   assign diff    = rem_ext - trial;
   // d*2^RECIP_W <= 2^NUM_LOG2 means the true quotient cannot fit; covers d=0.
   assign sat_new = (CMP_W'(denom) << RECIP_W) <= (CMP_W'(1) << NUM_LOG2);

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      d_d     = d_q;
      k_d     = k_q;
      q_d     = q_q;
      sat_d   = sat_q;
      recip_d = recip_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      if (state_q == RUN) begin
         if (trial <= rem_ext) begin
            rem_d = REM_W'(diff);
            q_d   = q_q | (RECIP_W'(1) << k_q);
         end
         k_d = k_q - K_W'(1);
         if (k_q == '0) begin
            recip_d = sat_q ? RECIP_MAX : q_d;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      end

      // A new request overrides both the next iteration and the return to IDLE.
      if (start) begin
         d_d     = denom;
         rem_d   = REM_INIT;
         k_d     = K_INIT;
         q_d     = '0;
         sat_d   = sat_new;
         busy_d  = 1'b1;
         state_d = RUN;
      end
   end

   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rem_q   <= '0;
         d_q     <= '0;
         k_q     <= '0;
         q_q     <= '0;
         sat_q   <= 1'b0;
         recip_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         d_q     <= d_d;
         k_q     <= k_d;
         q_q     <= q_d;
         sat_q   <= sat_d;
         recip_q <= recip_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign recip = recip_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_plane_recip_div.sv
// Directed bench for plane_recip_div: latency, sweep, saturation, restart,
// back-to-back commit/start and asynchronous reset mid-operation.
module tb_plane_recip_div;

   logic        clk48 = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [8:0]  denom = '0;
   logic [10:0] recip;
   logic        busy;
   logic        done;

   int total = 0;
   int bad   = 0;
   logic [10:0] last_recip = '0;

   plane_recip_div dut (
      .clk48 (clk48),
      .rst_n (rst_n),
      .start (start),
      .denom (denom),
      .recip (recip),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk48 = ~clk48;

   function automatic logic [10:0] recip_model(input int d);
      int q;
      if (d == 0) return 11'd2047;
      q = 65536 / d;
      return (q > 2047) ? 11'd2047 : 11'(q);
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge; start is sampled on the following posedge (E0).
   task automatic pulse_start(input int d);
      start = 1'b1;
      denom = 9'(d);
      @(negedge clk48);
      start = 1'b0;
      denom = 9'($urandom_range(0, 511));
   endtask

   task automatic expect_run(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         check({tag, " busy"}, int'(busy), 1);
         check({tag, " done"}, int'(done), 0);
         check({tag, " recip_hold"}, int'(recip), int'(last_recip));
         @(negedge clk48);
      end
   endtask

   task automatic expect_commit(input int d, input string tag);
      last_recip = recip_model(d);
      check({tag, " commit_done"}, int'(done), 1);
      check({tag, " commit_busy"}, int'(busy), 0);
      check({tag, " commit_recip"}, int'(recip), int'(last_recip));
   endtask

   task automatic full_op(input int d, input string tag);
      pulse_start(d);
      expect_run(11, tag);
      expect_commit(d, tag);
      @(negedge clk48);
      check({tag, " after_done"}, int'(done), 0);
      check({tag, " after_recip"}, int'(recip), int'(last_recip));
   endtask

   int sweep_d[5] = '{33, 100, 240, 272, 511};
   int sweep_q[5] = '{1985, 655, 273, 240, 128};
   int sat_d[3]   = '{0, 1, 32};

   initial begin
      // Reset state
      #2;
      check("rst recip", int'(recip), 0);
      check("rst busy", int'(busy), 0);
      check("rst done", int'(done), 0);
      repeat (2) @(negedge clk48);
      rst_n = 1'b1;
      @(negedge clk48);

      // 1: basic latency, recip stays 0 until commit
      full_op(256, "t1");
      check("t1 value", int'(recip), 256);

      // 2: sweep against the model and hand-computed values
      for (int i = 0; i < 5; i++) begin
         full_op(sweep_d[i], "t2");
         check("t2 hand", int'(recip), sweep_q[i]);
      end

      // 3: saturation, then no residual saturation
      for (int i = 0; i < 3; i++) begin
         full_op(sat_d[i], "t3");
         check("t3 sat", int'(recip), 2047);
      end
      full_op(33, "t3b");
      check("t3b hand", int'(recip), 1985);

      // 4: restart at E5 with a new denominator
      pulse_start(100);
      expect_run(4, "t4a");
      pulse_start(200);
      expect_run(11, "t4b");
      expect_commit(200, "t4b");
      check("t4 hand", int'(recip), 327);
      @(negedge clk48);
      check("t4 after_done", int'(done), 0);

      // 5: new start coincident with the final iteration
      pulse_start(256);
      expect_run(10, "t5a");
      pulse_start(50);
      last_recip = 11'd256;
      check("t5 first_done", int'(done), 1);
      check("t5 first_busy", int'(busy), 1);
      check("t5 first_recip", int'(recip), 256);
      @(negedge clk48);
      expect_run(10, "t5b");
      expect_commit(50, "t5b");
      check("t5 hand", int'(recip), 1310);
      @(negedge clk48);

      // 6: async reset in the middle of an operation
      pulse_start(100);
      expect_run(6, "t6a");
      rst_n = 1'b0;
      #1;
      last_recip = '0;
      check("t6 rst recip", int'(recip), 0);
      check("t6 rst busy", int'(busy), 0);
      check("t6 rst done", int'(done), 0);
      @(negedge clk48);
      rst_n = 1'b1;
      @(negedge clk48);
      full_op(64, "t6b");
      check("t6 hand", int'(recip), 1024);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/plane_recip_div.md
Name: plane_recip_div

Overview:
- Sequential radix-2 reciprocal divider feeding the 3D ground-plane renderer.
- Computes the per-scanline horizontal texture step: recip = min(2^NUM_LOG2 / denom, 2^RECIP_W-1).
- The renderer pulses start 16 clocks before the end of the visible line, with denom = plane_y+1. It samples recip at hblank, so the result must be committed within 16 clocks and held stable until the next commit.

Parameters:
- DENOM_W, 9: denominator width (unsigned).
- RECIP_W, 11: result width (unsigned); also the iteration count.
- NUM_LOG2, 16: numerator exponent; numerator = 2^NUM_LOG2.

Ports:
- clk48  in  1  system clock, 48 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; denom is sampled on the same edge.
- denom  in  DENOM_W  unsigned divisor.
- recip  out  RECIP_W  registered result; holds its value between commits.
- busy  out  1  high while a division is in flight.
- done  out  1  one-cycle pulse on the edge that commits recip.

Behaviour:
- Reset (async, any time including mid-operation):
  - recip=0, busy=0, done=0, FSM to IDLE.
  - Internal remainder, divisor and bit index cleared.
  - After reset, the first start behaves normally.
- States: IDLE, RUN.
- IDLE, start=1 at edge E0:
  - Latch d=denom and rem=2^NUM_LOG2 (NUM_LOG2+1 bits).
  - Set k=RECIP_W-1, clear the quotient shadow register, busy<=1, go to RUN.
  - Set sat=1 if d*2^RECIP_W <= 2^NUM_LOG2, which includes d=0. With the defaults, sat is set for d<=32.
- RUN, at each edge E1..E_RECIP_W (one iteration per edge):
  - If (d<<k) <= rem: rem <= rem-(d<<k) and q[k] <= 1.
  - Then k <= k-1.
  - Compare at full width, NUM_LOG2+2 bits minimum; no truncation of d<<k.
- Final iteration (k=0, edge E_RECIP_W):
  - recip <= sat ? 2^RECIP_W-1 : q, including the final bit.
  - done <= 1 for exactly one cycle; busy <= 0; go to IDLE.
- Saturated requests take the same RECIP_W-cycle latency as normal ones, so timing is deterministic.
- Latency: start at E0 → recip/done valid after E_RECIP_W. That is 11 clocks by default, inside the 16-clock budget.
- recip changes only on the commit edge. The shadow q is never visible on recip.
- start while busy (RUN): abort the current operation without committing or pulsing done, and restart from E0 with the new denom. recip keeps its last committed value.
- start on the same edge as the final iteration: the old result commits and done pulses. The new operation also begins on that edge (busy stays 1); the restart wins over the return to IDLE.
- denom changes while busy are ignored; only the value sampled with start is used.
- Result is exact floor division whenever the quotient is < 2^RECIP_W, i.e. no off-by-one.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset, then start with denom=256 at E0 → busy=1 for 11 cycles; done pulses once after E11; recip=256; recip stays at 0 until the commit edge.
2. Sweep denom=33, 100, 240, 272, 511 → recip = 1985, 655, 273, 240, 128 respectively, each with 11-cycle latency (compare against a bench model of floor(65536/d)).
3. Saturation: denom=0, 1, 32 → recip=2047 after 11 cycles each. Then denom=33 → recip=1985 with no residual saturation.
4. Restart: start denom=100, then start again at E5 with denom=200 → no done at the original E11; a single done 11 cycles after the second start; recip=327; recip keeps its prior value throughout.
5. Back-to-back: second start (denom=50) coincident with the first commit (denom=256) → recip=256 with done on that edge; busy stays high; recip=1310 with done 11 cycles later.
6. Async reset asserted at E6 of an operation (denom=100) → recip=0, busy=0, done=0 immediately with no clock. After release, start denom=64 → recip=1024.
